mem_access_ctrl: RTL

//  Sequences data-SRAM accesses for the MEM stage over an SRAM-like req/addr_ok/data_ok bus.

---
 rtl/mem_access_ctrl_pkg.sv | 31 +++
 rtl/mem_access_ctrl_store_align.sv | 39 +++
 rtl/mem_access_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data-SRAM access controller.
// State codes, size codes, data width and the asserted reset level.
// Also holds a small helper that classifies which states keep the pipeline stalled.
package mem_access_ctrl_pkg;

  // Access sequencer states
  typedef enum logic [2:0] {
    MC_IDLE  = 3'd0,
    MC_ADDR  = 3'd1,
    MC_DATA  = 3'd2,
    MC_DONE  = 3'd3,
    MC_DRAIN = 3'd4
  } mc_state_e;

  // MemSizeM encodings; code 3 is handled as a word
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // Only a 32-bit data bus is supported
  localparam int DATALENGTH = 32;

  // Level of the reset input that holds the block in reset
  localparam logic RESETABLE = 1'b0;

  // States that stall unconditionally while an access is in flight
  function automatic logic mc_busy(input mc_state_e s);
    return (s == MC_ADDR) || (s == MC_DATA) || (s == MC_DRAIN);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_store_align.sv
// Store lane alignment: byte strobes and lane-replicated write data from size/address.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs directly.
module mem_store_align
  import mem_access_ctrl_pkg::*;
(
  input  logic                  wr_i,
  input  logic [1:0]            size_i,
  input  logic [1:0]            addr_lo_i,
  input  logic [DATALENGTH-1:0] wdata_raw_i,
  output logic [3:0]            wstrb_o,
  output logic [DATALENGTH-1:0] wdata_o
);

  // Pick lanes by access size; loads never assert strobes
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = wdata_raw_i;
    case (size_i)
      SIZE_B: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_raw_i[7:0]}};
      end
      SIZE_H: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_raw_i[15:0]}};
      end
      default: begin
        // SIZE_W and the unused code 3 both act as a full word
        wstrb_o = 4'b1111;
        wdata_o = wdata_raw_i;
      end
    endcase
    if (!wr_i) begin
      wstrb_o = 4'b0000;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-SRAM access sequencer over a req/addr_ok/data_ok bus; captures load data.
// Latency: 3 cycles minimum (req+addr_ok, data_ok, DONE) with StallM high for the first 2.
// Backpressure: StallM/StallW hold the pipeline until the bus completes; MEMCTRL_STALL_CNT_EN adds StallCntO.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic [1:0]        MemSizeM,
  input  logic [ADDR_W-1:0] AddrM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              ExceptionM,
  input  logic              FlushM,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              StallW
`ifdef MEMCTRL_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  StallCntO
`endif
);

  mc_state_e         state_q, state_d;
  logic              flush_seen_q, flush_seen_d;
  logic              wr_q, wr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              go;
  logic              req_raw;
  logic              stall_raw;
  logic              run;

  // Outputs are held quiet while reset is asserted, independent of state
  assign run = (reset != RESETABLE);
  assign go  = MemReqM & ~ExceptionM & ~FlushM;

  // Address/size/write pass straight through from the MEM stage
  assign data_wr   = MemWriteM;
  assign data_size = MemSizeM;
  assign data_addr = AddrM;

  mem_store_align u_align (
    .wr_i        (MemWriteM),
    .size_i      (MemSizeM),
    .addr_lo_i   (AddrM[1:0]),
    .wdata_raw_i (WriteDataM),
    .wstrb_o     (data_wstrb),
    .wdata_o     (data_wdata)
  );

  // Next-state and request/stall decode
  always_comb begin
    state_d      = state_q;
    flush_seen_d = flush_seen_q;
    wr_d         = wr_q;
    rdata_d      = rdata_q;
    req_raw      = 1'b0;
    stall_raw    = mc_busy(state_q);
    case (state_q)
      MC_IDLE: begin
        req_raw      = go;
        stall_raw    = go;
        flush_seen_d = 1'b0;
        if (go) begin
          wr_d    = MemWriteM;
          state_d = data_addr_ok ? MC_DATA : MC_ADDR;
        end
      end
      MC_ADDR: begin
        // Once raised, the request stays up until the bus takes it
        req_raw = 1'b1;
        if (FlushM) begin
          flush_seen_d = 1'b1;
        end
        if (data_addr_ok) begin
          state_d = (flush_seen_q | FlushM) ? MC_DRAIN : MC_DATA;
        end
      end
      MC_DATA: begin
        if (data_data_ok) begin
          if (FlushM) begin
            // Response arrives together with the flush: drop it
            state_d = MC_IDLE;
          end else begin
            state_d = MC_DONE;
            if (!wr_q) begin
              rdata_d = data_rdata;
            end
          end
        end else if (FlushM) begin
          state_d = MC_DRAIN;
        end
      end
      MC_DONE: begin
        // One cycle with the stall released so the pipeline advances
        state_d = MC_IDLE;
      end
      MC_DRAIN: begin
        // Swallow the cancelled response before any new request
        if (data_data_ok) begin
          state_d = MC_IDLE;
        end
      end
      default: begin
        state_d   = MC_IDLE;
        stall_raw = 1'b0;
      end
    endcase
  end

  assign data_req  = run & req_raw;
  assign StallM    = run & stall_raw;
  assign StallW    = StallM;
  assign ReadDataM = rdata_q;

  // State and captured load data
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESETABLE) begin
      state_q      <= MC_IDLE;
      flush_seen_q <= 1'b0;
      wr_q         <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      flush_seen_q <= flush_seen_d;
      wr_q         <= wr_d;
      rdata_q      <= rdata_d;
    end
  end

`ifdef MEMCTRL_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Free-running count of stalled cycles, wrapping at full width
  always_comb begin
    cnt_d = cnt_q;
    if (StallM) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Stall counter register
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESETABLE) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign StallCntO = cnt_q;
`else
  // Counter width only matters when the counter is built
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule
